// File: rtl/text_pkg.sv
// Shared constants, control codes and state type for the text buffer.
// Geometry constants are also used by the pixel encoder for bounds checks.
package text_pkg;

  localparam int ROWS       = 7;
  localparam int COLS       = 20;
  localparam int FONT_CHARS = 130;
  localparam int NCELLS     = ROWS * COLS;

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam logic [2:0] LAST_ROW      = 3'(ROWS - 1);
  localparam logic [4:0] LAST_COL      = 5'(COLS - 1);
  localparam logic [3:0] ROWS_W        = 4'(ROWS);
  localparam logic [5:0] COLS_W        = 6'(COLS);
  localparam logic [7:0] ROW_STRIDE    = 8'(COLS);
  localparam logic [7:0] LAST_CELL     = 8'(NCELLS - 1);
  localparam logic [7:0] COPY_LAST     = 8'((ROWS - 1) * COLS - 1);
  localparam logic [7:0] LAST_ROW_BASE = 8'((ROWS - 1) * COLS);
  localparam logic [7:0] FONT_LIM      = 8'(FONT_CHARS);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCROLL_COPY,
    SCROLL_BLANK
  } state_t;

  function automatic logic [7:0] cell_addr(
    input logic [2:0] r,
    input logic [4:0] c
  );
    return 8'(r) * ROW_STRIDE + 8'(c);
  endfunction

  // Codes without a glyph are stored as a blank cell.
  function automatic logic [7:0] glyph(input logic [7:0] code);
    return (code >= FONT_LIM) ? BLANK : code;
  endfunction

endpackage

// File: rtl/text_buffer_writer_char_ram.sv
// Character store: one synchronous write port, two async read ports.
// Ports: clk, we/waddr/wdata (write), raddr_a/rdata_a, raddr_b/rdata_b.
module text_buffer_writer_char_ram
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [7:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [NCELLS];

  // Contents are not reset; the owner blanks the array after reset.
  always_ff @(posedge clk) begin
    if (we && (waddr <= LAST_CELL)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a <= LAST_CELL) ? mem[raddr_a] : BLANK;
  assign rdata_b = (raddr_b <= LAST_CELL) ? mem[raddr_b] : BLANK;

endmodule

// File: rtl/text_buffer_writer.sv
// Write side of the on-screen character buffer with cursor and scrolling.
// Ports: clk, rst_n, char_in/char_valid/char_ready (byte stream in),
//   rin/cin -> charout (display read), cursor_row, cursor_col, busy.
module text_buffer_writer
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [3:0] rin,
  input  logic [5:0] cin,
  output logic [7:0] charout,
  output logic [2:0] cursor_row,
  output logic [4:0] cursor_col,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [2:0] row_q, row_d;
  logic [4:0] col_q, col_d;

  logic       we;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic [7:0] raddr_a;
  logic [7:0] rdata_a;
  logic [7:0] raddr_b;
  logic [7:0] rdata_b;
  logic       in_range;
  logic       newline;

  logic is_lf, is_cr, is_bs, is_ff;
  logic is_ctl, is_prt;

  text_buffer_writer_char_ram u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  assign in_range = (rin < ROWS_W) && (cin < COLS_W);
  assign raddr_b  = in_range ? cell_addr(rin[2:0], cin[4:0]) : 8'd0;
  assign charout  = in_range ? rdata_b : BLANK;

  // Scroll copy source is one row below the destination.
  assign raddr_a = idx_q + ROW_STRIDE;

  assign char_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cursor_row = row_q;
  assign cursor_col = col_q;

  assign is_lf  = (char_in == CH_LF);
  assign is_cr  = (char_in == CH_CR);
  assign is_bs  = (char_in == CH_BS);
  assign is_ff  = (char_in == CH_FF);
  assign is_prt = (char_in >= BLANK);
  assign is_ctl = !is_prt && !is_lf && !is_cr && !is_bs && !is_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= 8'd0;
      row_q   <= 3'd0;
      col_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    we      = 1'b0;
    waddr   = idx_q;
    wdata   = BLANK;
    newline = 1'b0;

    unique case (state_q)
      CLEAR: begin
        we = 1'b1;
        if (idx_q == LAST_CELL) begin
          state_d = IDLE;
          idx_d   = 8'd0;
          row_d   = 3'd0;
          col_d   = 5'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      IDLE: begin
        if (char_valid) begin
          unique case (1'b1)
            is_lf: newline = 1'b1;
            is_cr: col_d = 5'd0;
            is_bs: begin
              if (col_q != 5'd0) begin
                col_d = col_q - 5'd1;
                we    = 1'b1;
                waddr = cell_addr(row_q, col_q - 5'd1);
              end else if (row_q != 3'd0) begin
                row_d = row_q - 3'd1;
                col_d = LAST_COL;
                we    = 1'b1;
                waddr = cell_addr(row_q - 3'd1, LAST_COL);
              end
            end
            is_ff: begin
              state_d = CLEAR;
              idx_d   = 8'd0;
            end
            is_ctl: ;
            is_prt: begin
              we    = 1'b1;
              waddr = cell_addr(row_q, col_q);
              wdata = glyph(char_in);
              if (col_q < LAST_COL) col_d = col_q + 5'd1;
              else                  newline = 1'b1;
            end
          endcase
        end
        // Cursor stays on the last row; the screen scrolls instead.
        if (newline) begin
          col_d = 5'd0;
          if (row_q < LAST_ROW) begin
            row_d = row_q + 3'd1;
          end else begin
            state_d = SCROLL_COPY;
            idx_d   = 8'd0;
          end
        end
      end

      SCROLL_COPY: begin
        we    = 1'b1;
        wdata = rdata_a;
        if (idx_q == COPY_LAST) begin
          state_d = SCROLL_BLANK;
          idx_d   = LAST_ROW_BASE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      SCROLL_BLANK: begin
        we = 1'b1;
        if (idx_q == LAST_CELL) begin
          state_d = IDLE;
          idx_d   = 8'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      default: begin
        state_d = CLEAR;
        idx_d   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed self-checking bench for text_buffer_writer.
// Drives and samples 1 time unit after the rising clock edge.
module tb_text_buffer_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [3:0] rin = 4'd0;
  logic [5:0] cin = 6'd0;
  logic [7:0] charout;
  logic [2:0] cursor_row;
  logic [4:0] cursor_col;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  text_buffer_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .rin        (rin),
    .cin        (cin),
    .charout    (charout),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int r, input int c, output logic [7:0] v);
    rin = 4'(r);
    cin = 6'(c);
    #1;
    v = charout;
  endtask

  task automatic send(input logic [7:0] code);
    int n = 0;
    while (!char_ready && n < 1000) begin
      sync();
      n++;
    end
    if (!char_ready) begin
      chk("send_ready", 32'(char_ready), 1);
      return;
    end
    char_in    = code;
    char_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    char_valid = 1'b0;
  endtask

  // Edges until char_ready rises, bounded.
  task automatic count_busy(output int n);
    n = 0;
    do begin
      sync();
      n++;
    end while (!char_ready && n < 1000);
  endtask

  task automatic chk_cursor(input string tag, input int r, input int c);
    chk(tag, {cursor_row, cursor_col}, {3'(r), 5'(c)});
  endtask

  task automatic chk_blank(input string tag);
    logic [7:0] v;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 20; c++) begin
        rd(r, c, v);
        chk(tag, v, 8'h20);
      end
    end
    sync();
  endtask

  initial begin
    int n;
    int a0;
    logic [7:0] v;

    // Reset state
    #2;
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 1);
    chk_cursor("rst_cursor", 0, 0);
    sync();
    rst_n = 1'b1;
    count_busy(n);
    chk("clear_cycles", n, 140);
    chk("clear_ready", char_ready, 1);
    chk("clear_busy", busy, 0);
    rd(7, 0, v);
    chk("oob_row", v, 8'h20);
    rd(0, 20, v);
    chk("oob_col", v, 8'h20);
    rd(15, 63, v);
    chk("oob_max", v, 8'h20);
    chk_blank("init_blank");

    // Back-to-back "AB"
    send(8'h41);
    a0 = acc_cyc;
    send(8'h42);
    chk("ab_consec", acc_cyc - a0, 1);
    rd(0, 0, v);
    chk("ab_00", v, 8'h41);
    rd(0, 1, v);
    chk("ab_01", v, 8'h42);
    sync();
    chk_cursor("ab_cursor", 0, 2);

    // Line wrap then backspace across the row boundary
    send(8'h0D);
    chk_cursor("cr_cursor", 0, 0);
    for (int i = 0; i < 20; i++) send(8'h41);
    send(8'h42);
    for (int c = 0; c < 20; c++) begin
      rd(0, c, v);
      chk("wrap_row0", v, 8'h41);
    end
    rd(1, 0, v);
    chk("wrap_10", v, 8'h42);
    sync();
    chk_cursor("wrap_cursor", 1, 1);
    send(8'h08);
    send(8'h08);
    rd(1, 0, v);
    chk("bs_10", v, 8'h20);
    rd(0, 19, v);
    chk("bs_019", v, 8'h20);
    rd(0, 18, v);
    chk("bs_018", v, 8'h41);
    sync();
    chk_cursor("bs_cursor", 0, 19);

    // Fill rows with digits, then scroll
    send(8'h0C);
    count_busy(n);
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 19; i++) send(8'(8'h30 + r));
      if (r < 6) send(8'h0A);
    end
    chk_cursor("fill_cursor", 6, 19);
    send(8'h0A);
    chk("scroll_ready0", char_ready, 0);
    count_busy(n);
    chk("scroll_cycles", n, 140);
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 20; c++) begin
        rd(r, c, v);
        if (r < 6 && c < 19) chk("scroll_cell", v, 8'(8'h31 + r));
        else                 chk("scroll_cell", v, 8'h20);
      end
    end
    sync();
    chk_cursor("scroll_cursor", 6, 0);

    // Form feed with content present
    send(8'h0C);
    count_busy(n);
    chk("ff_cycles", n, 140);
    chk_blank("ff_blank");
    chk_cursor("ff_cursor", 0, 0);
    send(8'h90);
    rd(0, 0, v);
    chk("hi_code", v, 8'h20);
    sync();
    chk_cursor("hi_cursor", 0, 1);
    send(8'h81);
    send(8'h82);
    rd(0, 1, v);
    chk("font_last", v, 8'h81);
    rd(0, 2, v);
    chk("font_over", v, 8'h20);
    sync();
    send(8'h01);
    chk_cursor("ctl_ignored", 0, 3);
    send(8'h0D);
    send(8'h08);
    chk_cursor("bs_origin", 0, 0);
    chk("bs_origin_rdy", char_ready, 1);

    // Character held across a clear is not lost
    send(8'h0C);
    send(8'h51);
    rd(0, 0, v);
    chk("held_char", v, 8'h51);
    sync();
    chk_cursor("held_cursor", 0, 1);

    // Reset in the middle of a scroll
    send(8'h0D);
    for (int i = 0; i < 6; i++) send(8'h0A);
    send(8'h5A);
    send(8'h0A);
    for (int i = 0; i < 49; i++) sync();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ready", char_ready, 0);
    chk_cursor("mid_rst_cursor", 0, 0);
    sync();
    rst_n = 1'b1;
    count_busy(n);
    chk("mid_clear_cycles", n, 140);
    chk_blank("mid_blank");
    chk_cursor("mid_cursor", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
